// File: rtl/noise_detector_window.sv
// noise_detector_window
// Two-stage salt-and-pepper noise detector for one WIN-pixel filter window.
// S1 registers the per-pixel noisy flags. S2 registers the flags, their
// popcount, the centre flag and the all-noisy flag. Both stages advance
// together whenever the output register is empty or being drained.
// A saturating counter tallies transferred results whose centre is noisy.
module noise_detector_window #(
    parameter int PIX_W  = 8,
    parameter int WIN    = 9,
    parameter int MODE   = 2,
    parameter int FCNT_W = 20,
    localparam int CW    = $clog2(WIN + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIN*PIX_W-1:0] win_pix,
    input  logic [PIX_W-1:0]     lo_th,
    input  logic [PIX_W-1:0]     hi_th,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 frame_clr,
    output logic [WIN-1:0]       flags,
    output logic [CW-1:0]        noise_cnt,
    output logic                 centre_noisy,
    output logic                 all_noisy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [FCNT_W-1:0]    frame_cnt
);

    localparam int C = WIN / 2;

    // Which conditions count as noise in this build.
    localparam logic USE_PEPPER = (MODE != 1);
    localparam logic USE_SALT   = (MODE != 0);

    logic                 adv;
    logic [WIN-1:0]       det_flags;
    logic                 s1_valid_reg;
    logic [WIN-1:0]       s1_flags_reg;
    logic [CW-1:0]        cnt_next;
    logic                 out_valid_reg;
    logic [WIN-1:0]       flags_reg;
    logic [CW-1:0]        noise_cnt_reg;
    logic                 centre_noisy_reg;
    logic                 all_noisy_reg;
    logic [FCNT_W-1:0]    frame_cnt_reg;
    logic                 xfer;

    // The whole pipeline moves when the output slot is free or emptying;
    // in_ready never looks at in_valid.
    assign adv      = !out_valid_reg || out_ready;
    assign in_ready = adv;
    assign xfer     = out_valid_reg && out_ready;

    // Per-pixel detection against the thresholds present at accept time;
    // a pixel matching both conditions is simply flagged once.
    for (genvar gi = 0; gi < WIN; gi++) begin : g_det
        logic [PIX_W-1:0] pix;
        logic             pepper;
        logic             salt;
        assign pix    = win_pix[gi*PIX_W +: PIX_W];
        assign pepper = (pix <= lo_th);
        assign salt   = (pix >= hi_th);
        assign det_flags[gi] = (USE_PEPPER && pepper) || (USE_SALT && salt);
    end

    // Stage 1: capture the raw flags and the window valid bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_flags_reg <= '0;
        end else if (adv) begin
            s1_valid_reg <= in_valid;
            s1_flags_reg <= det_flags;
        end
    end

    // Popcount of the stage-1 flags feeding stage 2.
    always_comb begin
        cnt_next = '0;
        for (int i = 0; i < WIN; i++) begin
            cnt_next = cnt_next + CW'(s1_flags_reg[i]);
        end
    end

    // Stage 2: output register; holds everything steady while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg    <= 1'b0;
            flags_reg        <= '0;
            noise_cnt_reg    <= '0;
            centre_noisy_reg <= 1'b0;
            all_noisy_reg    <= 1'b0;
        end else if (adv) begin
            out_valid_reg    <= s1_valid_reg;
            flags_reg        <= s1_flags_reg;
            noise_cnt_reg    <= cnt_next;
            centre_noisy_reg <= s1_flags_reg[C];
            all_noisy_reg    <= (cnt_next == CW'(WIN));
        end
    end

    // Frame counter: clear beats increment; sticks at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_reg <= '0;
        end else if (frame_clr) begin
            frame_cnt_reg <= '0;
        end else if (xfer && centre_noisy_reg && (frame_cnt_reg != {FCNT_W{1'b1}})) begin
            frame_cnt_reg <= frame_cnt_reg + 1'b1;
        end
    end

    assign out_valid    = out_valid_reg;
    assign flags        = flags_reg;
    assign noise_cnt    = noise_cnt_reg;
    assign centre_noisy = centre_noisy_reg;
    assign all_noisy    = all_noisy_reg;
    assign frame_cnt    = frame_cnt_reg;

endmodule
